spi_xfer_arbiter: RTL
=====================

# spi_xfer_arbiter

Sequencer and arbiter that shares the single three-channel SPI master among three requesters, one per slave. It accepts 16-bit transfer requests, grants one at a time, drives the master's chip-select and transmit-data inputs for a fixed transfer window, then captures the master's received word and returns it to the winning requester. It sits between the requesters and `spi_master`, replacing direct top-level drive of `cs1/cs2/cs3` and `master_data`.

## Interface
- `DATA_W`, 16: transfer word width; must match the master.
- `XFER_CYCLES`, 16: cycles a chip-select is held per transfer (≥1).
- `GAP_CYCLES`, 2: idle cycles with all chip-selects low between transfers (≥0).
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  3  per-requester transfer request, level; bit i targets slave i+1.
- `req_data`  in  3*DATA_W  transmit words; requester i uses bits [i*DATA_W +: DATA_W].
- `ack`  out  3  one-cycle pulse: request i granted, `req_data` slice captured.
- `done`  out  3  one-cycle pulse: transfer i complete, `rx_data` valid.
- `rx_data`  out  DATA_W  word captured from `master_r` at completion; held until next completion.
- `busy`  out  1  high in every state except IDLE.
- `master_r`  in  DATA_W  received word from `spi_master`.
- `cs1`, `cs2`, `cs3`  out  1 each  active-high chip-select to master; at most one high.
- `master_data`  out  DATA_W  transmit word to master; held stable while any cs is high.

## Operation
- States: IDLE, XFER, CAPTURE, GAP.
- IDLE: if any `req` bit is high, select winner via round-robin starting at `ptr`; register `master_data <= req_data` slice, `cs[winner] <= 1`, `ack[winner] <= 1`, counter <= 0, go XFER. No request: stay.
- XFER: counter increments each cycle; when counter == XFER_CYCLES-1, drop all cs, go CAPTURE.
- CAPTURE: `rx_data <= master_r`, `done[winner] <= 1`, `ptr <= (winner+1) mod 3`; go GAP if GAP_CYCLES>0 else IDLE.
- GAP: count GAP_CYCLES cycles, then IDLE.
- Round-robin: from `ptr`, first set bit scanning upward with wrap (ptr=2, req=3'b011 → grant 0).
- Requester rule: hold `req` and its data stable until `ack`; deassert `req` the cycle after `ack`. A `req` still high in the next IDLE is a new request.
- `req` changes during XFER/CAPTURE/GAP are ignored; sampled only in IDLE.
- Reset (any time, including mid-XFER): all outputs 0, `ptr`=0, state IDLE, counters 0; aborted transfer produces no `done`.

## Timing
- Reset values: `ack`=0, `done`=0, `rx_data`=0, `busy`=0, `cs1..3`=0, `master_data`=0.
- Request seen in IDLE at edge N → `ack`, cs, `master_data` valid after edge N (cycle N+1).
- cs high exactly XFER_CYCLES cycles (cycles N+1 … N+XFER_CYCLES).
- `done` and `rx_data` valid in cycle N+XFER_CYCLES+1; `master_r` sampled at that edge.
- Next grant earliest in cycle N+XFER_CYCLES+GAP_CYCLES+2; back-to-back period = XFER_CYCLES+GAP_CYCLES+2.
- `ack` and `done` never coincide for the same requester; `done` for one may not coincide with `ack` for another (GAP/IDLE intervene).

## Configuration
- `SPI_ARB_FIXED_PRIO_EN`: defined → fixed priority, requester 0 highest, 2 lowest; `ptr` not implemented. Undefined (default) → round-robin as above. All timing identical.

## Structure
- Package `spi_pkg`: state enum (IDLE, XFER, CAPTURE, GAP), `NUM_SLV`=3, default `DATA_W`.
- Sub-module `spi_rr_arbiter`: combinational one-hot grant from `req` and `ptr`; contains the `SPI_ARB_FIXED_PRIO_EN` switch.
- Top-level instantiates this block between requesters and `spi_master`.

## Test plan
- Single request: req=3'b010, data1=16'hA5C3 → ack=3'b010 next cycle, cs2 high 16 cycles, master_data=16'hA5C3, done=3'b010 with rx_data=master_r (drive 16'h1234).
- Round-robin: req=3'b111 held, requesters drop after ack and reassert → grant order 0,1,2,0; period 20 cycles with defaults.
- Wrap: after grant 2, req=3'b101 → grant 0; with `SPI_ARB_FIXED_PRIO_EN`, after grant 0, req=3'b011 → grant 0 again.
- Reset mid-XFER: reset low at cycle 8 of transfer → cs, busy low immediately; no done; after release, req=3'b001 → grant 0 (ptr reset).
- Ignored requests: req=3'b100 raised during XFER of requester 0 → no ack until IDLE; then ack=3'b100.
- GAP_CYCLES=0: back-to-back requests → period 18 cycles, cs one-hot, never two high.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, requester count and default word width
// for the SPI transfer arbiter and its grant logic.
package spi_pkg;

    localparam int NUM_SLV    = 3;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        CAPTURE = 2'd2,
        GAP     = 2'd3
    } state_t;

    // Index of the set bit in a one-hot requester vector (0 when empty).
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_SLV-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter: combinational one-hot grant for the three SPI requesters.
// Default: round-robin, scanning upward from ptr with wrap.
// SPI_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 highest, and
// the ptr port is not present.
module spi_rr_arbiter
    import spi_pkg::*;
(
`ifndef SPI_ARB_FIXED_PRIO_EN
    input  logic [1:0]         ptr,
`endif
    input  logic [NUM_SLV-1:0] req,
    output logic [NUM_SLV-1:0] grant
);

`ifdef SPI_ARB_FIXED_PRIO_EN
    // Lowest-numbered active requester wins.
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`else
    // First active requester at or above ptr, wrapping past the top.
    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_SLV; k++) begin
            idx = (int'(ptr) + k) % NUM_SLV;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: shares one three-channel SPI master among three
// requesters. Grants one request at a time, holds its chip-select and
// transmit word for XFER_CYCLES, returns the received word with a done
// pulse, then idles GAP_CYCLES before the next grant.
// Build option: SPI_ARB_FIXED_PRIO_EN selects fixed priority instead of
// round-robin (timing unchanged).
module spi_xfer_arbiter
    import spi_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int XFER_CYCLES = 16,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SLV-1:0]        req,
    input  logic [NUM_SLV*DATA_W-1:0] req_data,
    output logic [NUM_SLV-1:0]        ack,
    output logic [NUM_SLV-1:0]        done,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      busy,
    input  logic [DATA_W-1:0]         master_r,
    output logic                      cs1,
    output logic                      cs2,
    output logic                      cs3,
    output logic [DATA_W-1:0]         master_data
);

    // One counter serves both the transfer window and the inter-transfer gap.
    localparam int CNT_MAX = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] XFER_LAST = CNT_W'(XFER_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_SLV-1:0]  cs_q, cs_d;
    logic [NUM_SLV-1:0]  ack_q, ack_d;
    logic [NUM_SLV-1:0]  done_q, done_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic [DATA_W-1:0]   master_data_q, master_data_d;
    logic [NUM_SLV-1:0]  grant;

`ifndef SPI_ARB_FIXED_PRIO_EN
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          win_idx;

    assign win_idx = onehot_to_idx(cs_q);

    spi_rr_arbiter u_arb (
        .ptr   (ptr_q),
        .req   (req),
        .grant (grant)
    );
`else
    spi_rr_arbiter u_arb (
        .req   (req),
        .grant (grant)
    );
`endif

    // Next-state and registered-output logic for the transfer sequencer.
    // NOTE: every variable gets its hold/default value first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cs_d          = cs_q;
        ack_d         = '0;
        done_d        = '0;
        rx_data_d     = rx_data_q;
        master_data_d = master_data_q;
`ifndef SPI_ARB_FIXED_PRIO_EN
        ptr_d         = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    cs_d  = grant;
                    ack_d = grant;
                    cnt_d = '0;
                    for (int i = 0; i < NUM_SLV; i++) begin
                        if (grant[i]) master_data_d = req_data[i*DATA_W +: DATA_W];
                    end
                    state_d = XFER;
                end
            end
            XFER: begin
                // The completion outputs are registered on the edge that
                // closes the window, so they are visible during CAPTURE.
                if (cnt_q == XFER_LAST) begin
                    cs_d      = '0;
                    done_d    = cs_q;
                    rx_data_d = master_r;
                    cnt_d     = '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
                    ptr_d     = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
`endif
                    state_d   = CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAPTURE: begin
                cnt_d   = '0;
                state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transfer silently.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cs_q          <= '0;
            ack_q         <= '0;
            done_q        <= '0;
            rx_data_q     <= '0;
            master_data_q <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
            ptr_q         <= 2'd0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cs_q          <= cs_d;
            ack_q         <= ack_d;
            done_q        <= done_d;
            rx_data_q     <= rx_data_d;
            master_data_q <= master_data_d;
`ifndef SPI_ARB_FIXED_PRIO_EN
            ptr_q         <= ptr_d;
`endif
        end
    end

    assign ack         = ack_q;
    assign done        = done_q;
    assign rx_data     = rx_data_q;
    assign busy        = (state_q != IDLE);
    assign cs1         = cs_q[0];
    assign cs2         = cs_q[1];
    assign cs3         = cs_q[2];
    assign master_data = master_data_q;

endmodule
